// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline control blocks: write-back source
// codes, forwarding mux selects, multiplier tracker states and a register
// compare helper that treats $zero as never matching.
package mips_pkg;

    localparam logic [2:0] WB_ALU = 3'b000;
    localparam logic [2:0] WB_MEM = 3'b001;
    localparam logic [2:0] WB_HI  = 3'b010;
    localparam logic [2:0] WB_LO  = 3'b011;
    localparam logic [2:0] WB_PC8 = 3'b100;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MULT_IDLE = 1'b0,
        MULT_BUSY = 1'b1
    } mult_state_t;

    // $zero is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/mult_tracker.sv
// Multiplier occupancy tracker. The FSM state is exported so the parent can
// derive mult_busy and so checkers can observe the FSM directly.
//
// mcnt is loaded with MULT_LAT-1 when a multiply issues and counts down once
// per BUSY cycle. The tracker leaves BUSY after the cycle in which mcnt is 1
// (or 0 when MULT_LAT is 1), so the issue cycle plus the BUSY cycles span
// exactly MULT_LAT cycles for MULT_LAT >= 2, and MULT_LAT = 1 still gets one
// BUSY cycle. A second multstartE while BUSY reloads the counter.
import mips_pkg::*;

module mult_tracker #(
    parameter int MULT_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        multstartE,
    output mult_state_t state
);

    localparam logic [3:0] LAT_LOAD = 4'(MULT_LAT - 1);

    mult_state_t state_next;
    logic [3:0]  mcnt;
    logic [3:0]  mcnt_next;

    // State and counter registers; reset may land mid-multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MULT_IDLE;
            mcnt  <= 4'd0;
        end else begin
            state <= state_next;
            mcnt  <= mcnt_next;
        end
    end

    // Next-state and countdown logic.
    always_comb begin
        state_next = state;
        mcnt_next  = mcnt;
        case (state)
            MULT_IDLE: begin
                if (multstartE) begin
                    state_next = MULT_BUSY;
                    mcnt_next  = LAT_LOAD;
                end
            end
            MULT_BUSY: begin
                if (multstartE) begin
                    mcnt_next = LAT_LOAD;
                end else if (mcnt <= 4'd1) begin
                    state_next = MULT_IDLE;
                    mcnt_next  = 4'd0;
                end else begin
                    mcnt_next = mcnt - 4'd1;
                end
            end
            default: begin
                state_next = MULT_IDLE;
                mcnt_next  = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// All stall/flush/forward outputs are combinational from the current stage
// fields; the only state is the multiplier tracker and the stall counter.
// While rst is high every control output is held low.
import mips_pkg::*;

module hazard_unit #(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [1:0]       branchD,
    input  logic [2:0]       wbsrcD,
    input  logic             multstartD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic             RegWriteE,
    input  logic [2:0]       WBSrcE,
    input  logic             multstartE,
    input  logic [4:0]       writeregM,
    input  logic             RegWriteM,
    input  logic [2:0]       WBSrcM,
    input  logic [4:0]       writeregW,
    input  logic             RegWriteW,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mult_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    mult_state_t mult_state;
    logic        busy_raw;
    logic        lwstall;
    logic        brstall;
    logic        multstall;
    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    mult_tracker #(
        .MULT_LAT (MULT_LAT)
    ) u_mult_tracker (
        .clk        (clk),
        .rst        (rst),
        .multstartE (multstartE),
        .state      (mult_state)
    );

    // Execute-stage operand selects; the younger M result beats W.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (RegWriteM && reg_match(writeregM, rsE))      fwd_a = FWD_MEM;
        else if (RegWriteW && reg_match(writeregW, rsE)) fwd_a = FWD_WB;
        if (RegWriteM && reg_match(writeregM, rtE))      fwd_b = FWD_MEM;
        else if (RegWriteW && reg_match(writeregW, rtE)) fwd_b = FWD_WB;
    end

    // Stall sources: load-use, branch compare not yet resolvable, and
    // HI/LO readers or a second multiply while the multiplier is occupied.
    always_comb begin
        busy_raw  = (mult_state == MULT_BUSY) || multstartE;
        lwstall   = RegWriteE && (WBSrcE == WB_MEM) &&
                    (reg_match(writeregE, rsD) || reg_match(writeregE, rtD));
        brstall   = (branchD != 2'b00) &&
                    ((RegWriteE && (reg_match(writeregE, rsD) || reg_match(writeregE, rtD))) ||
                     (RegWriteM && (WBSrcM == WB_MEM) &&
                      (reg_match(writeregM, rsD) || reg_match(writeregM, rtD))));
        multstall = busy_raw && (multstartD || (wbsrcD == WB_HI) || (wbsrcD == WB_LO));
        stall     = !rst && (lwstall || brstall || multstall);
    end

    // Output drive, forced quiet while reset is asserted.
    always_comb begin
        stallF    = stall;
        stallD    = stall;
        flushE    = stall;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        mult_busy = 1'b0;
        if (!rst) begin
            forwardAD = RegWriteM && reg_match(writeregM, rsD) && (WBSrcM != WB_MEM);
            forwardBD = RegWriteM && reg_match(writeregM, rtD) && (WBSrcM != WB_MEM);
            forwardAE = fwd_a;
            forwardBE = fwd_b;
            mult_busy = busy_raw;
        end
    end

    // Saturating count of cycles in which decode was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. The driver applies one vector per cycle
// shortly after the rising edge and pushes the hand-computed response; the
// monitor pops and compares on the falling edge. A second instance with a
// 4-bit counter shares the same stimulus to exercise counter saturation.
module tb_hazard_unit;

    localparam int MULT_LAT = 4;
    localparam int W        = 46;   // {ctl[9:0], cnt32[31:0], cnt4[3:0]}

    logic       clk;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic [1:0] branchD;
    logic [2:0] wbsrcD, WBSrcE, WBSrcM;
    logic       multstartD, RegWriteE, multstartE, RegWriteM, RegWriteW;

    logic        stallF, stallD, flushE, forwardAD, forwardBD, mult_busy;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] stall_cnt;

    logic        s_stallF, s_stallD, s_flushE, s_forwardAD, s_forwardBD, s_mult_busy;
    logic [1:0]  s_forwardAE, s_forwardBE;
    logic [3:0]  s_stall_cnt;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [31:0]  exp_cnt;
    logic [3:0]   exp_cnt4;
    logic         stim_done;
    int           checks;
    int           errors;

    hazard_unit #(.MULT_LAT(MULT_LAT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .wbsrcD(wbsrcD),
        .multstartD(multstartD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .RegWriteE(RegWriteE), .WBSrcE(WBSrcE), .multstartE(multstartE),
        .writeregM(writeregM), .RegWriteM(RegWriteM), .WBSrcM(WBSrcM),
        .writeregW(writeregW), .RegWriteW(RegWriteW),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .forwardAD(forwardAD),
        .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mult_busy(mult_busy), .stall_cnt(stall_cnt)
    );

    hazard_unit #(.MULT_LAT(MULT_LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .wbsrcD(wbsrcD),
        .multstartD(multstartD), .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .RegWriteE(RegWriteE), .WBSrcE(WBSrcE), .multstartE(multstartE),
        .writeregM(writeregM), .RegWriteM(RegWriteM), .WBSrcM(WBSrcM),
        .writeregW(writeregW), .RegWriteW(RegWriteW),
        .stallF(s_stallF), .stallD(s_stallD), .flushE(s_flushE), .forwardAD(s_forwardAD),
        .forwardBD(s_forwardBD), .forwardAE(s_forwardAE), .forwardBE(s_forwardBE),
        .mult_busy(s_mult_busy), .stall_cnt(s_stall_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic clear_inputs();
        rsD = 5'd0; rtD = 5'd0; branchD = 2'b00; wbsrcD = 3'b000; multstartD = 1'b0;
        rsE = 5'd0; rtE = 5'd0; writeregE = 5'd0; RegWriteE = 1'b0; WBSrcE = 3'b000;
        multstartE = 1'b0; writeregM = 5'd0; RegWriteM = 1'b0; WBSrcM = 3'b000;
        writeregW = 5'd0; RegWriteW = 1'b0;
    endtask

    task automatic assert_rst();
        rst      = 1'b1;
        exp_cnt  = 32'd0;
        exp_cnt4 = 4'd0;
    endtask

    // Inputs for this cycle are already applied; record the expected response,
    // then advance to just past the next rising edge, tracking the counters.
    task automatic cyc(input string nm, input logic st, input logic fad, input logic fbd,
                       input logic [1:0] fae, input logic [1:0] fbe, input logic busy);
        exp_q.push_back({st, st, st, fad, fbd, fae, fbe, busy, exp_cnt, exp_cnt4});
        name_q.push_back(nm);
        @(posedge clk);
        if (rst) begin
            exp_cnt  = 32'd0;
            exp_cnt4 = 4'd0;
        end else if (st) begin
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            if (exp_cnt4 != 4'hF)         exp_cnt4 = exp_cnt4 + 4'd1;
        end
        #1;
    endtask

    // Scoreboard monitor and final report
    initial begin : monitor
        logic [W-1:0] e;
        logic [W-1:0] act;
        logic [9:0]   s_act;
        string        nm;
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
                       mult_busy, stall_cnt, s_stall_cnt};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got ctl=%b cnt=%0d cnt4=%0d, expected ctl=%b cnt=%0d cnt4=%0d",
                             nm, act[45:36], act[35:4], act[3:0], e[45:36], e[35:4], e[3:0]);
                end
                s_act = {s_stallF, s_stallD, s_flushE, s_forwardAD, s_forwardBD,
                         s_forwardAE, s_forwardBE, s_mult_busy};
                checks++;
                if (s_act !== e[45:36]) begin
                    errors++;
                    $display("FAIL %s (cnt4 instance): got ctl=%b, expected ctl=%b",
                             nm, s_act, e[45:36]);
                end
            end else if (stim_done) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    // Directed stimulus
    initial begin
        stim_done = 1'b0;
        exp_cnt   = 32'd0;
        exp_cnt4  = 4'd0;
        clear_inputs();
        assert_rst();
        // Hazards present during reset must not reach the outputs.
        RegWriteM = 1'b1; writeregM = 5'd8; rsE = 5'd8; multstartE = 1'b1; wbsrcD = 3'b010;
        RegWriteE = 1'b1; WBSrcE = 3'b001; writeregE = 5'd5; rtD = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset forced", 0, 0, 0, 2'b00, 2'b00, 0);
        clear_inputs();
        rst = 1'b0;
        cyc("idle after reset", 0, 0, 0, 2'b00, 2'b00, 0);

        // Forwarding priority and $zero
        RegWriteM = 1; writeregM = 5'd8; RegWriteW = 1; writeregW = 5'd8; rsE = 5'd8;
        cyc("fwdAE M over W", 0, 0, 0, 2'b10, 2'b00, 0);
        RegWriteM = 0;
        cyc("fwdAE W only", 0, 0, 0, 2'b01, 2'b00, 0);
        RegWriteM = 1; rsE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        cyc("fwdAE reg0", 0, 0, 0, 2'b00, 2'b00, 0);
        rsE = 5'd7; writeregM = 5'd7; rtE = 5'd9; writeregW = 5'd9;
        cyc("fwdAE M fwdBE W", 0, 0, 0, 2'b10, 2'b01, 0);

        // Load-use: one stall cycle, then the producer sits in M
        clear_inputs();
        RegWriteE = 1; WBSrcE = 3'b001; writeregE = 5'd5; rtD = 5'd5;
        cyc("load-use stall", 1, 0, 0, 2'b00, 2'b00, 0);
        clear_inputs();
        rtD = 5'd5; RegWriteM = 1; writeregM = 5'd5; WBSrcM = 3'b001;
        cyc("load-use released", 0, 0, 0, 2'b00, 2'b00, 0);
        clear_inputs();
        RegWriteE = 1; WBSrcE = 3'b000; writeregE = 5'd5; rsD = 5'd5;
        cyc("alu producer no stall", 0, 0, 0, 2'b00, 2'b00, 0);
        RegWriteE = 0; WBSrcE = 3'b001;
        cyc("load no regwrite", 0, 0, 0, 2'b00, 2'b00, 0);
        RegWriteE = 1; writeregE = 5'd0; rsD = 5'd0; rtD = 5'd0;
        cyc("load to reg0", 0, 0, 0, 2'b00, 2'b00, 0);

        // Branch hazards
        clear_inputs();
        branchD = 2'b01; rsD = 5'd3; RegWriteE = 1; writeregE = 5'd3;
        cyc("branch E producer", 1, 0, 0, 2'b00, 2'b00, 0);
        RegWriteE = 0; writeregE = 5'd0; RegWriteM = 1; writeregM = 5'd3; WBSrcM = 3'b000;
        cyc("branch M alu fwd", 0, 1, 0, 2'b00, 2'b00, 0);
        WBSrcM = 3'b001;
        cyc("branch M load", 1, 0, 0, 2'b00, 2'b00, 0);
        clear_inputs();
        branchD = 2'b10; rtD = 5'd4; RegWriteM = 1; writeregM = 5'd4; WBSrcM = 3'b010;
        cyc("branch fwdBD", 0, 0, 1, 2'b00, 2'b00, 0);
        clear_inputs();
        rsD = 5'd3; RegWriteE = 1; writeregE = 5'd3;
        cyc("no branch no stall", 0, 0, 0, 2'b00, 2'b00, 0);

        // Multiply occupancy: mflo held behind a multiply
        clear_inputs();
        multstartE = 1; wbsrcD = 3'b011;
        cyc("mult c0", 1, 0, 0, 2'b00, 2'b00, 1);
        multstartE = 0;
        cyc("mult c1", 1, 0, 0, 2'b00, 2'b00, 1);
        cyc("mult c2", 1, 0, 0, 2'b00, 2'b00, 1);
        cyc("mult c3", 1, 0, 0, 2'b00, 2'b00, 1);
        cyc("mult c4 done", 0, 0, 0, 2'b00, 2'b00, 0);

        // Multiply followed by another multiply and mfhi
        clear_inputs();
        multstartE = 1;
        cyc("mult2 c0", 0, 0, 0, 2'b00, 2'b00, 1);
        multstartE = 0; multstartD = 1;
        cyc("mult2 c1 multD", 1, 0, 0, 2'b00, 2'b00, 1);
        multstartD = 0; wbsrcD = 3'b010;
        cyc("mult2 c2 mfhi", 1, 0, 0, 2'b00, 2'b00, 1);
        wbsrcD = 3'b000;
        cyc("mult2 c3", 0, 0, 0, 2'b00, 2'b00, 1);
        wbsrcD = 3'b010;
        cyc("mult2 c4 done", 0, 0, 0, 2'b00, 2'b00, 0);
        wbsrcD = 3'b000; multstartD = 1;
        cyc("multD idle", 0, 0, 0, 2'b00, 2'b00, 0);

        // Restart while busy reloads the counter
        clear_inputs();
        multstartE = 1;
        cyc("restart c0", 0, 0, 0, 2'b00, 2'b00, 1);
        multstartE = 0;
        cyc("restart c1", 0, 0, 0, 2'b00, 2'b00, 1);
        multstartE = 1;
        cyc("restart c2", 0, 0, 0, 2'b00, 2'b00, 1);
        multstartE = 0;
        cyc("restart c3", 0, 0, 0, 2'b00, 2'b00, 1);
        cyc("restart c4", 0, 0, 0, 2'b00, 2'b00, 1);
        cyc("restart c5", 0, 0, 0, 2'b00, 2'b00, 1);
        cyc("restart c6 done", 0, 0, 0, 2'b00, 2'b00, 0);

        // Reset in the middle of a multiply
        clear_inputs();
        multstartE = 1; wbsrcD = 3'b011;
        cyc("rst mult c0", 1, 0, 0, 2'b00, 2'b00, 1);
        multstartE = 0;
        cyc("rst mult c1", 1, 0, 0, 2'b00, 2'b00, 1);
        assert_rst();
        cyc("rst mult asserted", 0, 0, 0, 2'b00, 2'b00, 0);
        rst = 1'b0;
        wbsrcD = 3'b010;
        cyc("after rst mfhi", 0, 0, 0, 2'b00, 2'b00, 0);
        cyc("after rst mfhi 2", 0, 0, 0, 2'b00, 2'b00, 0);

        // Continuous load-use stall saturates the 4-bit counter
        clear_inputs();
        RegWriteE = 1; WBSrcE = 3'b001; writeregE = 5'd5; rtD = 5'd5;
        for (int i = 0; i < 20; i++) begin
            cyc("sat stall", 1, 0, 0, 2'b00, 2'b00, 0);
        end
        clear_inputs();
        cyc("sat hold", 0, 0, 0, 2'b00, 2'b00, 0);
        cyc("sat hold 2", 0, 0, 0, 2'b00, 2'b00, 0);

        stim_done = 1'b1;
        repeat (50) @(posedge clk);
        $display("FAIL drain: %0d expectations still queued, required 0", exp_q.size());
        $fatal(1, "scoreboard did not drain");
    end

endmodule
